// File: rtl/inst_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_sequencer_if
//  Purpose  : Bundles the instruction-memory, decode-handshake and redirect
//             signals of the fetch sequencer.
//  Modports : master - the fetch sequencer (drives address, fetch outputs)
//             slave  - memory/decode/branch side (drives read data, ready,
//                      branch redirect)
//  Signals  : Inst_Address[63:0], Instruction[31:0], Fetch_Valid,
//             Fetch_Ready, Fetch_Instruction[31:0], Fetch_PC[63:0],
//             Branch_Taken, Branch_Target[63:0], Fetch_Fault
//  Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_sequencer_if;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        Fetch_Valid;
    logic        Fetch_Ready;
    logic [31:0] Fetch_Instruction;
    logic [63:0] Fetch_PC;
    logic        Branch_Taken;
    logic [63:0] Branch_Target;
    logic        Fetch_Fault;

    modport master (
        output Inst_Address,
        input  Instruction,
        output Fetch_Valid,
        input  Fetch_Ready,
        output Fetch_Instruction,
        output Fetch_PC,
        input  Branch_Taken,
        input  Branch_Target,
        output Fetch_Fault
    );

    modport slave (
        input  Inst_Address,
        output Instruction,
        input  Fetch_Valid,
        output Fetch_Ready,
        input  Fetch_Instruction,
        input  Fetch_PC,
        output Branch_Taken,
        output Branch_Target,
        input  Fetch_Fault
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_sequencer
//  Purpose  : Owns the program counter, fetches 32-bit words from the
//             byte-addressed instruction memory, presents them to decode via
//             a valid/ready handshake, applies branch redirects and raises a
//             sticky fault on misaligned or out-of-range fetches.
//  Ports    : clk   - single clock, rising edge
//             reset - asynchronous, active-high
//             bus   - inst_fetch_sequencer_if.master (memory address/data,
//                     decode handshake, branch redirect, fault flag)
//  Params   : MEM_BYTES - instruction memory size in bytes (multiple of 4)
//             RESET_PC  - word-aligned PC loaded on reset
//  Options  : IFU_BRANCH_BYPASS_EN - when defined, a redirect drives the
//             target straight onto Inst_Address and fetches it on the same
//             edge (no bubble); otherwise the redirect costs one bubble.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_sequencer #(
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  wire logic               clk,
    input  wire logic               reset,
    inst_fetch_sequencer_if.master  bus
);

    localparam logic [1:0]  S_FETCH     = 2'd0;
    localparam logic [1:0]  S_VALID     = 2'd1;
    localparam logic [1:0]  S_FAULT     = 2'd2;
    localparam logic [64:0] c_MEM_LIMIT = 65'(MEM_BYTES);

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic        r_valid;
    logic [31:0] r_inst;
    logic [63:0] r_fpc;
    logic        r_fault;

    logic [63:0] w_fetch_addr;
    logic [63:0] w_next_pc;
    logic        w_fetch_legal;
    logic        w_attempt;      // try to fetch w_fetch_addr this edge
    logic        w_load_target;  // bubble redirect: load PC only

    // The address presented to memory is also the address whose legality is
    // checked and whose word is captured, so one path serves both normal
    // fetches and bypassed redirects.
`ifdef IFU_BRANCH_BYPASS_EN
    assign w_fetch_addr = (bus.Branch_Taken && (r_state != S_FAULT)) ?
                          bus.Branch_Target : r_pc;
`else
    assign w_fetch_addr = r_pc;
`endif

    // 65-bit compare so an address near 2^64 cannot wrap into range.
    assign w_fetch_legal = (w_fetch_addr[1:0] == 2'b00) &&
                           (({1'b0, w_fetch_addr} + 65'd4) <= c_MEM_LIMIT);
    assign w_next_pc     = w_fetch_addr + 64'd4;

    always_comb begin
        w_attempt     = 1'b0;
        w_load_target = 1'b0;
        case (r_state)
            S_FETCH: begin
`ifdef IFU_BRANCH_BYPASS_EN
                w_attempt     = 1'b1;
`else
                w_load_target = bus.Branch_Taken;
                w_attempt     = !bus.Branch_Taken;
`endif
            end
            S_VALID: begin
`ifdef IFU_BRANCH_BYPASS_EN
                w_attempt     = bus.Branch_Taken || bus.Fetch_Ready;
`else
                // Redirect outranks ready: the held word is discarded.
                w_load_target = bus.Branch_Taken;
                w_attempt     = !bus.Branch_Taken && bus.Fetch_Ready;
`endif
            end
            default: begin
                // FAULT is terminal until reset; redirects are ignored.
                w_attempt     = 1'b0;
                w_load_target = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_inst  <= 32'd0;
            r_fpc   <= 64'd0;
            r_fault <= 1'b0;
        end else if (w_load_target) begin
            r_pc    <= bus.Branch_Target;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
        end else if (w_attempt) begin
            if (w_fetch_legal) begin
                r_inst  <= bus.Instruction;
                r_fpc   <= w_fetch_addr;
                r_pc    <= w_next_pc;
                r_valid <= 1'b1;
                r_state <= S_VALID;
            end else begin
                // PC freezes at the faulting address (a bypassed target
                // included) so the failing fetch stays visible.
                r_pc    <= w_fetch_addr;
                r_valid <= 1'b0;
                r_fault <= 1'b1;
                r_state <= S_FAULT;
            end
        end
    end

    assign bus.Inst_Address      = w_fetch_addr;
    assign bus.Fetch_Valid       = r_valid;
    assign bus.Fetch_Instruction = r_inst;
    assign bus.Fetch_PC          = r_fpc;
    assign bus.Fetch_Fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_sequencer
//  Purpose  : Self-checking bench for inst_fetch_sequencer: directed
//             scenarios with fixed expectations plus a randomized run
//             checked against a behavioural fetch model.
//  Options  : IFU_BRANCH_BYPASS_EN selects the zero-bubble redirect model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_sequencer;

    localparam int unsigned MEM_BYTES = 128;
`ifdef IFU_BRANCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        ready;
    logic        br;
    logic [63:0] tgt;
    logic [31:0] mem [0:31];

    int n_pass  = 0;
    int n_total = 0;

    inst_fetch_sequencer_if bus ();

    inst_fetch_sequencer #(
        .MEM_BYTES (MEM_BYTES),
        .RESET_PC  (64'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.Fetch_Ready   = ready;
    assign bus.Branch_Taken  = br;
    assign bus.Branch_Target = tgt;
    assign bus.Instruction   = (bus.Inst_Address < 64'(MEM_BYTES)) ?
                               mem[bus.Inst_Address[6:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state: the next address to fetch, the word held for
    // decode, and whether the sequencer has faulted.
    logic [63:0] m_pc;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_inst;
    logic [63:0] m_fpc;

    function automatic bit legal(input logic [63:0] a);
        return (a % 4 == 0) && (a <= 64'(MEM_BYTES - 4));
    endfunction

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return mem[int'(a >> 2)];
    endfunction

    task automatic model_fetch(input logic [63:0] a);
        if (legal(a)) begin
            m_valid = 1'b1;
            m_inst  = word_at(a);
            m_fpc   = a;
            m_pc    = a + 64'd4;
        end else begin
            m_valid = 1'b0;
            m_fault = 1'b1;
            m_pc    = a;
        end
    endtask

    task automatic model_step(input bit rdy, input bit b, input logic [63:0] t);
        if (m_fault) return;
        if (b) begin
            if (BYPASS) model_fetch(t);
            else begin
                m_valid = 1'b0;
                m_pc    = t;
            end
        end else if (!m_valid || rdy) begin
            model_fetch(m_pc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ready = 1'b0;
        br    = 1'b0;
        tgt   = 64'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        tick();
        n_total++;
        if ({bus.Fetch_Valid, bus.Fetch_Fault, bus.Fetch_Instruction,
             bus.Fetch_PC} !== 98'd0)
            $display("FAIL reset_outputs: got v=%b f=%b inst=%h pc=%h, want all 0",
                     bus.Fetch_Valid, bus.Fetch_Fault, bus.Fetch_Instruction,
                     bus.Fetch_PC);
        else n_pass++;
        n_total++;
        if (bus.Inst_Address !== 64'd0)
            $display("FAIL reset_addr: got %h want 0", bus.Inst_Address);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] exp_w [0:2];
        exp_w[0] = 32'h0000_0B33;
        exp_w[1] = 32'h0000_0BB3;
        exp_w[2] = 32'h0000_02B3;
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (!(bus.Fetch_Valid === 1'b1 && bus.Fetch_PC === 64'(4 * k) &&
                  bus.Fetch_Instruction === exp_w[k]))
                $display("FAIL stream_%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         k, bus.Fetch_Valid, bus.Fetch_PC, bus.Fetch_Instruction,
                         64'(4 * k), exp_w[k]);
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++;
            if (!(bus.Fetch_Valid === 1'b1 && bus.Fetch_PC === 64'd4 &&
                  bus.Fetch_Instruction === 32'h0000_0BB3))
                $display("FAIL stall_hold_%0d: got v=%b pc=%h inst=%h want v=1 pc=4 inst=00000bb3",
                         k, bus.Fetch_Valid, bus.Fetch_PC, bus.Fetch_Instruction);
            else n_pass++;
        end
        ready = 1'b1;
        tick();
        n_total++;
        if (!(bus.Fetch_Valid === 1'b1 && bus.Fetch_PC === 64'd8 &&
              bus.Fetch_Instruction === 32'h0000_02B3))
            $display("FAIL stall_release: got v=%b pc=%h inst=%h want v=1 pc=8 inst=000002b3",
                     bus.Fetch_Valid, bus.Fetch_PC, bus.Fetch_Instruction);
        else n_pass++;
    endtask

    // Runs straight after test_stall: a word is valid and ready is high.
    task automatic test_branch();
        br  = 1'b1;
        tgt = 64'd124;
        #1;
        n_total++;
        if (bus.Inst_Address !== (BYPASS ? 64'd124 : 64'd12))
            $display("FAIL branch_addr: got %h want %h", bus.Inst_Address,
                     BYPASS ? 64'd124 : 64'd12);
        else n_pass++;
        tick();
        br = 1'b0;
        if (!BYPASS) begin
            n_total++;
            if (bus.Fetch_Valid !== 1'b0)
                $display("FAIL branch_bubble: got v=%b want 0", bus.Fetch_Valid);
            else n_pass++;
            tick();
        end
        n_total++;
        if (!(bus.Fetch_Valid === 1'b1 && bus.Fetch_PC === 64'd124 &&
              bus.Fetch_Instruction === 32'hFE00_00E3))
            $display("FAIL branch_target: got v=%b pc=%h inst=%h want v=1 pc=7c inst=fe0000e3",
                     bus.Fetch_Valid, bus.Fetch_PC, bus.Fetch_Instruction);
        else n_pass++;
    endtask

    task automatic test_fault_end();
        ready = 1'b1;
        tick();
        n_total++;
        if (!(bus.Fetch_Fault === 1'b1 && bus.Fetch_Valid === 1'b0 &&
              bus.Inst_Address === 64'd128))
            $display("FAIL end_fault: got f=%b v=%b addr=%h want f=1 v=0 addr=80",
                     bus.Fetch_Fault, bus.Fetch_Valid, bus.Inst_Address);
        else n_pass++;
        br  = 1'b1;
        tgt = 64'd0;
        tick();
        br = 1'b0;
        tick();
        n_total++;
        if (!(bus.Fetch_Fault === 1'b1 && bus.Fetch_Valid === 1'b0 &&
              bus.Inst_Address === 64'd128))
            $display("FAIL fault_ignores_branch: got f=%b v=%b addr=%h want f=1 v=0 addr=80",
                     bus.Fetch_Fault, bus.Fetch_Valid, bus.Inst_Address);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        do_reset();
        br  = 1'b1;
        tgt = 64'd6;
        tick();
        br = 1'b0;
        tick();
        n_total++;
        if (!(bus.Fetch_Fault === 1'b1 && bus.Fetch_Valid === 1'b0 &&
              bus.Inst_Address === 64'd6))
            $display("FAIL misaligned: got f=%b v=%b addr=%h want f=1 v=0 addr=6",
                     bus.Fetch_Fault, bus.Fetch_Valid, bus.Inst_Address);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        ready = 1'b1;
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        n_total++;
        if ({bus.Fetch_Valid, bus.Fetch_Fault, bus.Fetch_Instruction,
             bus.Fetch_PC, bus.Inst_Address} !== 162'd0)
            $display("FAIL async_reset: got v=%b f=%b inst=%h pc=%h addr=%h want all 0",
                     bus.Fetch_Valid, bus.Fetch_Fault, bus.Fetch_Instruction,
                     bus.Fetch_PC, bus.Inst_Address);
        else n_pass++;
        tick();
        reset = 1'b0;
        tick();
        n_total++;
        if (!(bus.Fetch_Valid === 1'b1 && bus.Fetch_PC === 64'd0 &&
              bus.Fetch_Instruction === 32'h0000_0B33))
            $display("FAIL async_resume: got v=%b pc=%h inst=%h want v=1 pc=0 inst=00000b33",
                     bus.Fetch_Valid, bus.Fetch_PC, bus.Fetch_Instruction);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] exp_addr;
        int          sel;
        do_reset();
        m_pc = 64'd0; m_valid = 1'b0; m_fault = 1'b0;
        m_inst = 32'd0; m_fpc = 64'd0;
        for (int i = 0; i < 600; i++) begin
            if (m_fault && $urandom_range(0, 3) == 0) begin
                do_reset();
                m_pc = 64'd0; m_valid = 1'b0; m_fault = 1'b0;
                continue;
            end
            ready = ($urandom_range(0, 3) != 0);
            br    = ($urandom_range(0, 9) == 0);
            sel   = int'($urandom_range(0, 9));
            if (sel < 7)       tgt = {57'd0, 5'($urandom_range(0, 31)), 2'b00};
            else if (sel == 7) tgt = 64'd124;
            else if (sel == 8) tgt = {57'd0, 7'($urandom_range(0, 127)) | 7'd1};
            else               tgt = ($urandom_range(0, 1) != 0) ?
                                     64'hFFFF_FFFF_FFFF_FFFC : 64'd128;
            #1;
            exp_addr = (BYPASS && br && !m_fault) ? tgt : m_pc;
            n_total++;
            if (bus.Inst_Address !== exp_addr)
                $display("FAIL rand_addr_%0d: got %h want %h", i,
                         bus.Inst_Address, exp_addr);
            else n_pass++;
            model_step(ready, br, tgt);
            tick();
            n_total++;
            if (!(bus.Fetch_Valid === m_valid && bus.Fetch_Fault === m_fault))
                $display("FAIL rand_flags_%0d: got v=%b f=%b want v=%b f=%b", i,
                         bus.Fetch_Valid, bus.Fetch_Fault, m_valid, m_fault);
            else n_pass++;
            if (m_valid) begin
                n_total++;
                if (!(bus.Fetch_PC === m_fpc && bus.Fetch_Instruction === m_inst))
                    $display("FAIL rand_word_%0d: got pc=%h inst=%h want pc=%h inst=%h",
                             i, bus.Fetch_PC, bus.Fetch_Instruction, m_fpc, m_inst);
                else n_pass++;
            end
        end
        br = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ready = 1'b0;
        br    = 1'b0;
        tgt   = 64'd0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[0]  = 32'h0000_0B33;
        mem[1]  = 32'h0000_0BB3;
        mem[2]  = 32'h0000_02B3;
        mem[31] = 32'hFE00_00E3;

        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_fault_end();
        test_misaligned();
        test_async_reset();
        test_random();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
